// File: rtl/ws2812_frame_driver.sv
// WS2812 chain driver: internal GRB pixel RAM, brightness scaling, one-shot or continuous frame refresh.
// Outputs are registered from the FSM state, so they lag the internal state by one cycle.
module ws2812_frame_driver #(
    parameter int unsigned LED_NUM  = 32,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned T0H_CYC  = 20,
    parameter int unsigned T1H_CYC  = 40,
    parameter int unsigned TBIT_CYC = 63,
    parameter int unsigned TRST_CYC = 15000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [7:0]        brightness,
    output logic              busy,
    output logic              frame_done,
    output logic              signal_out
);
    localparam int unsigned CW = $clog2(TBIT_CYC);
    localparam int unsigned GW = $clog2(TRST_CYC);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LED_NUM - 1);

    typedef enum logic [1:0] {IDLE, FETCH, BIT, GAP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        br_q, br_d;
    logic [23:0]       sh_q, sh_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [4:0]        bidx_q, bidx_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sig_q, sig_d;

    logic [23:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] fetch_addr;
    logic [23:0]       fetch_raw;
    logic [23:0]       fetch_px;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return 8'(p >> 8);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < LED_NUM))
            mem[wr_addr] <= wr_data;
    end

    // Same-edge write bypass: a write landing on the fetch edge is seen by that fetch.
    always_comb begin
        fetch_addr = (state_q == FETCH) ? '0 : pix_q + 1'b1;
        fetch_raw  = (wr_en && (wr_addr == fetch_addr)) ? wr_data : mem[fetch_addr];
        fetch_px   = {scale(fetch_raw[23:16], br_q), scale(fetch_raw[15:8], br_q),
                      scale(fetch_raw[7:0], br_q)};
    end

    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        pix_d   = pix_q;
        gcnt_d  = gcnt_q;
        busy_d  = (state_q != IDLE);
        done_d  = (state_q == GAP) && (gcnt_q == GW'(TRST_CYC - 1));
        sig_d   = (state_q == BIT) &&
                  (bcnt_q < (sh_q[23] ? CW'(T1H_CYC) : CW'(T0H_CYC)));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    br_d    = brightness;
                end
            end
            FETCH: begin
                sh_d    = fetch_px;
                bcnt_d  = '0;
                bidx_d  = '0;
                pix_d   = '0;
                state_d = BIT;
            end
            BIT: begin
                if (bcnt_q == CW'(TBIT_CYC - 1)) begin
                    bcnt_d = '0;
                    if (bidx_q == 5'd23) begin
                        bidx_d = '0;
                        if (pix_q == LAST_PIX) begin
                            state_d = GAP;
                            gcnt_d  = '0;
                        end else begin
                            pix_d = pix_q + 1'b1;
                            sh_d  = fetch_px;
                        end
                    end else begin
                        bidx_d = bidx_q + 5'd1;
                        sh_d   = {sh_q[22:0], 1'b0};
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == GW'(TRST_CYC - 1)) begin
                    if (cont_mode) begin
                        state_d = FETCH;
                        br_d    = brightness;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            br_q    <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            pix_q   <= '0;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            pix_q   <= pix_d;
            gcnt_q  <= gcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign signal_out = sig_q;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Bench for ws2812_frame_driver: a timeline model of each frame (relative to the accept edge) checked every cycle.
module tb_ws2812_frame_driver;
    localparam int L     = 2;
    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int TBIT  = 63;
    localparam int TRST  = 200;
    localparam int PIXC  = 24 * TBIT;
    localparam int BITS  = L * PIXC;
    localparam int FRAME = 1 + BITS + TRST;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        wr_en = 0;
    logic [5:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        start = 0;
    logic        cont_mode = 0;
    logic [7:0]  brightness = 8'd255;
    logic        busy, frame_done, signal_out;

    ws2812_frame_driver #(
        .LED_NUM(L), .ADDR_W(6), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .TBIT_CYC(TBIT), .TRST_CYC(TRST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .cont_mode(cont_mode), .brightness(brightness),
        .busy(busy), .frame_done(frame_done), .signal_out(signal_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [23:0] mram [L];
    logic [23:0] snap [L];
    logic        m_act = 0;
    logic        m_tail = 0;
    int          mk = 0;
    int          mbr = 0;
    int          widths[$];
    int          done_cyc[$];
    int          run = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] scale_px(input logic [23:0] p, input int b);
        int g, r, bl;
        g  = (int'(p[23:16]) * (b + 1)) / 256;
        r  = (int'(p[15:8]) * (b + 1)) / 256;
        bl = (int'(p[7:0]) * (b + 1)) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    // Model update at each edge, then compare outputs 1 time unit later.
    always @(posedge clk) begin
        logic e_busy, e_done, e_sig, bv;
        int t, u, j;
        cyc++;
        if (!rst_n) begin
            m_act  = 0;
            m_tail = 0;
        end else begin
            m_tail = 0;
            if (wr_en && wr_addr < L) mram[wr_addr] = wr_data;
            if (m_act && (cyc - mk == FRAME)) begin
                m_tail = 1;
                if (cont_mode) begin
                    mk  = cyc;
                    mbr = brightness;
                end else begin
                    m_act = 0;
                end
            end else if (!m_act && start) begin
                m_act = 1;
                mk    = cyc;
                mbr   = brightness;
            end
            if (m_act) begin
                t = cyc - mk;
                for (int n = 0; n < L; n++)
                    if (t == 1 + n * PIXC) snap[n] = scale_px(mram[n], mbr);
            end
        end
        #1;
        e_busy = 0; e_done = 0; e_sig = 0;
        if (m_tail) begin
            e_busy = 1;
            e_done = 1;
        end else if (m_act) begin
            t = cyc - mk;
            e_busy = (t >= 1);
            if (t >= 2 && t < 2 + BITS) begin
                u  = t - 2;
                j  = u / TBIT;
                bv = snap[j / 24][23 - (j % 24)];
                e_sig = ((u % TBIT) < (bv ? T1H : T0H));
            end
        end
        chk("busy", busy, e_busy);
        chk("frame_done", frame_done, e_done);
        chk("signal_out", signal_out, e_sig);
        if (signal_out) run++;
        else if (run > 0) begin
            widths.push_back(run);
            run = 0;
        end
        if (frame_done) done_cyc.push_back(cyc);
    end

    task automatic write_pix(input logic [5:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < lim, 1'b1);
    endtask

    initial begin
        int bad, c0, n;
        repeat (5) @(negedge clk);
        rst_n = 1;

        // Frame 1: full brightness, known bit pattern.
        write_pix(6'd0, 24'hFF0000);
        write_pix(6'd1, 24'h000001);
        write_pix(6'd5, 24'hFFFFFF);
        brightness = 8'd255;
        widths.delete();
        pulse_start();
        wait_idle(2 * FRAME);
        chk("f1_pulse_count", widths.size(), 48);
        if (widths.size() == 48) begin
            bad = 0;
            for (int i = 0; i < 48; i++)
                if (widths[i] != ((i < 8 || i == 47) ? 40 : 20)) bad++;
            chk("f1_pulse_widths_bad", bad, 0);
        end

        // Frame 2: brightness 127, ignored start, write on pixel 1 fetch edge, input brightness changed mid-frame.
        brightness = 8'd127;
        write_pix(6'd0, 24'h80FF40);
        pulse_start();
        repeat (300) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        brightness = 8'd200;
        wr_en = 1; wr_addr = 6'd5; wr_data = 24'h123456;
        @(negedge clk);
        wr_en = 0;
        repeat (1210) @(negedge clk);
        wr_en = 1; wr_addr = 6'd1; wr_data = 24'hFFFFFF;
        @(negedge clk);
        wr_en = 0;
        wait_idle(2 * FRAME);
        chk("f2_model_pix0", snap[0], 24'h407F20);
        chk("f2_model_pix1", snap[1], 24'h7F7F7F);

        // Frame 3: brightness 0 -> every bit is a '0'.
        brightness = 8'd0;
        widths.delete();
        pulse_start();
        wait_idle(2 * FRAME);
        chk("f3_pulse_count", widths.size(), 48);
        bad = 0;
        foreach (widths[i]) if (widths[i] != 20) bad++;
        chk("f3_pulse_widths_bad", bad, 0);

        // Continuous mode, then drop cont_mode mid-frame.
        brightness = 8'd255;
        cont_mode = 1;
        done_cyc.delete();
        pulse_start();
        n = 0;
        while (done_cyc.size() < 2 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("cont_timeout", n < 3 * FRAME, 1'b1);
        if (done_cyc.size() >= 2)
            chk("cont_period", done_cyc[1] - done_cyc[0], 3225);
        repeat (500) @(negedge clk);
        cont_mode = 0;
        c0 = done_cyc.size();
        wait_idle(2 * FRAME);
        chk("cont_extra_done", done_cyc.size() - c0, 1);

        // Asynchronous reset mid-bit while the line is high.
        pulse_start();
        n = 0;
        while (!signal_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sig_high_timeout", n < 200, 1'b1);
        #2;
        rst_n = 0;
        #1;
        chk("rst_signal_out", signal_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
